// File: rtl/gamma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gamma_pkg
// Description : Shared definitions for the inverse-gamma (linearising) stage:
//               default pixel width, controller state encoding and the
//               default-table rule (saturating left shift).
// Revision    : 1.0 - initial release
// ============================================================================
package gamma_pkg;

    // Default luminance width; LUT depth is 2**c_DATA_W.
    localparam int c_DATA_W = 8;

    // Controller states: table initialisation, then normal streaming.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default table entry: addr << shift, clamped to the largest value that
    // fits in dataW bits. Evaluated in 64 bits so the clamp sees the true
    // shifted value instead of a wrapped one.
    function automatic int unsigned default_entry(
        input int unsigned addr,
        input int unsigned shift,
        input int unsigned dataW = c_DATA_W
    );
        longint unsigned maxVal;
        longint unsigned val;
        maxVal = (64'd1 << dataW) - 64'd1;
        val    = 64'(addr) << shift;
        if (val > maxVal) begin
            val = maxVal;
        end
        return 32'(val);
    endfunction

endpackage : gamma_pkg
`default_nettype wire

// File: rtl/gamma_lut_ram.sv
`default_nettype none
// ============================================================================
// Module      : gamma_lut_ram
// Description : Simple dual-port 2**DATA_W x DATA_W RAM. One write port and
//               one synchronous, enabled read port. A read and a write to the
//               same address in the same cycle return the old contents
//               (read-before-write). No reset, so it maps onto block RAM.
// Ports       : iCLK   - clock
//               iWE    - write enable
//               iWADDR - write address
//               iWDATA - write data
//               iRE    - read enable; oRDATA holds while low
//               iRADDR - read address
//               oRDATA - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module gamma_lut_ram #(
    parameter int DATA_W = 8
) (
    input  logic              iCLK,
    input  logic              iWE,
    input  logic [DATA_W-1:0] iWADDR,
    input  logic [DATA_W-1:0] iWDATA,
    input  logic              iRE,
    input  logic [DATA_W-1:0] iRADDR,
    output logic [DATA_W-1:0] oRDATA
);

    localparam int c_DEPTH = 1 << DATA_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdData;

    // Both ports in one block with non-blocking updates: the read samples the
    // array before this edge's write lands, giving read-before-write.
    always_ff @(posedge iCLK) begin
        if (iWE) begin
            r_mem[iWADDR] <= iWDATA;
        end
        if (iRE) begin
            r_rdData <= r_mem[iRADDR];
        end
    end

    assign oRDATA = r_rdData;

endmodule : gamma_lut_ram
`default_nettype wire

// File: rtl/inverse_gamma_lut.sv
`default_nettype none
// ============================================================================
// Module      : inverse_gamma_lut
// Description : Streaming inverse-gamma stage. After reset the table is
//               filled with the default rule (one entry per cycle, 2**DATA_W
//               cycles), then pixels stream through a fixed 2-cycle pipeline:
//               register inputs, then synchronous LUT read (or bypass).
//               The host may rewrite table entries while running.
// Ports       : iCLK       - pixel clock
//               iRST_N     - asynchronous active-low reset
//               iY         - gamma-encoded luminance
//               iDVAL      - iY valid
//               iBYPASS    - pass iY through unchanged (per pixel)
//               iLUT_WE    - host table write strobe (ignored during INIT)
//               iLUT_ADDR  - host write address
//               iLUT_DATA  - host write data
//               oY         - linearised luminance (holds when oDVAL low)
//               oDVAL      - oY valid
//               oINIT_DONE - table initialised, block running
// Revision    : 1.0 - initial release
// ============================================================================
module inverse_gamma_lut
    import gamma_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int DEF_SHIFT = 1
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [DATA_W-1:0] iY,
    input  logic              iDVAL,
    input  logic              iBYPASS,
    input  logic              iLUT_WE,
    input  logic [DATA_W-1:0] iLUT_ADDR,
    input  logic [DATA_W-1:0] iLUT_DATA,
    output logic [DATA_W-1:0] oY,
    output logic              oDVAL,
    output logic              oINIT_DONE
);

    localparam logic [DATA_W-1:0] c_LAST_ADDR = '1;

    state_t            r_state;
    logic [DATA_W-1:0] r_initCnt;
    logic              r_initDone;

    logic              r_s1Valid;
    logic              r_s1Bypass;
    logic [DATA_W-1:0] r_s1Y;
    logic              r_s2Valid;
    logic              r_s2Bypass;
    logic [DATA_W-1:0] r_s2Y;

    logic              w_run;
    logic              w_accept;
    logic              w_ramWe;
    logic [DATA_W-1:0] w_ramAddr;
    logic [DATA_W-1:0] w_ramData;
    logic              w_ramRe;
    logic [DATA_W-1:0] w_ramQ;

    assign w_run    = (r_state == RUN);
    assign w_accept = iDVAL & w_run;

    // ------------------------------------------------------------------
    // Write-port owner: the init generator during INIT, the host in RUN.
    // Host strobes during INIT are simply dropped.
    // ------------------------------------------------------------------
    always_comb begin
        w_ramWe   = 1'b0;
        w_ramAddr = r_initCnt;
        w_ramData = DATA_W'(default_entry(32'(r_initCnt),
                                          $unsigned(DEF_SHIFT),
                                          $unsigned(DATA_W)));
        if (r_state == INIT) begin
            w_ramWe = 1'b1;
        end else if (iLUT_WE) begin
            w_ramWe   = 1'b1;
            w_ramAddr = iLUT_ADDR;
            w_ramData = iLUT_DATA;
        end
    end

    // ------------------------------------------------------------------
    // Controller: walk every address once, then stay in RUN until reset.
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= INIT;
            r_initCnt  <= '0;
            r_initDone <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_initCnt <= r_initCnt + DATA_W'(1);
                    if (r_initCnt == c_LAST_ADDR) begin
                        r_state    <= RUN;
                        r_initDone <= 1'b1;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Two-stage pixel pipeline. Stage-2 data fields only load on a valid
    // pixel, and the RAM read is only enabled for non-bypassed pixels, so
    // oY holds its last value while oDVAL is low. Stage-2 bypass resets to
    // 1 with a zero pixel so oY reads 0 out of reset without touching the
    // (unreset) RAM output register.
    // ------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_s1Valid  <= 1'b0;
            r_s1Bypass <= 1'b0;
            r_s1Y      <= '0;
            r_s2Valid  <= 1'b0;
            r_s2Bypass <= 1'b1;
            r_s2Y      <= '0;
        end else begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Y      <= iY;
                r_s1Bypass <= iBYPASS;
            end
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Y      <= r_s1Y;
                r_s2Bypass <= r_s1Bypass;
            end
        end
    end

    assign w_ramRe = r_s1Valid & ~r_s1Bypass;

    gamma_lut_ram #(
        .DATA_W (DATA_W)
    ) u_lutRam (
        .iCLK   (iCLK),
        .iWE    (w_ramWe),
        .iWADDR (w_ramAddr),
        .iWDATA (w_ramData),
        .iRE    (w_ramRe),
        .iRADDR (r_s1Y),
        .oRDATA (w_ramQ)
    );

    assign oY         = r_s2Bypass ? r_s2Y : w_ramQ;
    assign oDVAL      = r_s2Valid;
    assign oINIT_DONE = r_initDone;

endmodule : inverse_gamma_lut
`default_nettype wire

// File: doc/inverse_gamma_lut.md
Name: inverse_gamma_lut

Overview:
- Streaming inverse-gamma (linearising) stage for 8-bit luminance.
- Decode-side counterpart of the forward gamma pass in the video path, which currently encodes with y = x>>1.
- Maps each incoming encoded Y through a 256-entry LUT. Default table is the exact inverse of the halving pass; the host can reprogram the table at run time.
- Sits after the gamma stage in the pixel pipeline, ahead of any block needing linear luminance.

Parameters:
- DATA_W, 8, pixel width; LUT depth is 2**DATA_W.
- DEF_SHIFT, 1, default table rule: entry[a] = min(a << DEF_SHIFT, 2**DATA_W-1).

Ports:
- iCLK  in  1  pixel clock.
- iRST_N  in  1  asynchronous active-low reset.
- iY  in  DATA_W  gamma-encoded luminance.
- iDVAL  in  1  iY valid this cycle.
- iBYPASS  in  1  1 = pass iY through unchanged; sampled with each pixel.
- iLUT_WE  in  1  host table write strobe.
- iLUT_ADDR  in  DATA_W  host write address.
- iLUT_DATA  in  DATA_W  host write data.
- oY  out  DATA_W  linearised luminance.
- oDVAL  out  1  oY valid.
- oINIT_DONE  out  1  table initialised; block is in RUN.

Behaviour:
- Reset (asynchronous, iRST_N low):
  - oY=0, oDVAL=0, oINIT_DONE=0.
  - Pipeline valid bits cleared, init counter=0, state=INIT.
  - LUT contents are not reset; INIT rewrites them.
- State machine:
  - INIT: one entry written per cycle, addr = counter, data = default rule; counter increments.
  - INIT -> RUN after writing address 2**DATA_W-1 (256 cycles). oINIT_DONE rises on the first RUN cycle and stays high until reset.
  - RUN: terminal state; leaves only on reset.
- During INIT:
  - iDVAL is ignored: no output pixels, oDVAL=0.
  - Host writes are ignored (dropped, not queued).
- Pipeline in RUN, fixed latency 2, no back-pressure:
  - cycle t: iY, iDVAL, iBYPASS registered (stage 1).
  - cycle t+1: synchronous LUT read at the registered address. oY = bypass ? registered iY : LUT data. oDVAL = stage-1 valid. Both are registered and visible at t+2.
  - Back-to-back pixels are accepted every cycle, full throughput.
- Output hold: when oDVAL=0, oY holds its last value (not zeroed).
- Host write in RUN: takes effect at the clock edge where iLUT_WE=1.
- Read/write collision: a pixel whose LUT read (cycle t+1) coincides with a write to the same address gets the OLD entry (read-before-write). Pixels read in later cycles see the new entry.
- Width rule: default-table entries saturate at 2**DATA_W-1 (e.g. a=200, shift 1 -> 255). No other arithmetic.
- Reset mid-stream: in-flight pixels are discarded (oDVAL low from the reset assertion), and after release the block repeats the full 256-cycle INIT.
- Mid-INIT reset: counter restarts at 0.

Decomposition:
- Shared package (gamma_pkg):
  - DATA_W default.
  - State enum {INIT, RUN}.
  - Function default_entry(addr, shift) implementing the saturating shift, reused by the bench model.
- One sub-module, gamma_lut_ram: simple dual-port 2**DATA_W x DATA_W RAM, one write port and one synchronous read port, read-before-write, inferable to M10K.
- Top level holds the FSM, the init counter, write-port muxing (INIT generator vs host) and the two-stage pipeline.

Test Plan:
- Release reset, drive iDVAL=1 continuously -> oDVAL stays 0 and oINIT_DONE=0 for 256 cycles. oINIT_DONE=1 on cycle 257. No output pixels produced from the ignored inputs.
- After INIT, stream iY=0,1,64,127,128,255 back-to-back -> oY=0,2,128,254,255,255, each exactly 2 cycles after input, oDVAL high 6 consecutive cycles.
- Host writes addr 10 <- 0x55, then iY=10 -> oY=0x55. Same write issued in the cycle addr 10 is read for a pixel -> that pixel gets 20; the next iY=10 gets 0x55.
- iBYPASS=1 with iY=0x80 -> oY=0x80. Next pixel iBYPASS=0, iY=0x80 -> oY=0xFF (per-pixel bypass, no glitch).
- Assert iRST_N low for 1 cycle with 2 pixels in flight -> oDVAL drops immediately, no stale pixel emerges. INIT reruns, and a previous host write to addr 10 is overwritten back to 20.
- Host write during INIT (addr 5 <- 0xAA) -> ignored; after INIT, iY=5 -> oY=10.
